imm_encode: RTL and testbench

IMM_ENCODE -- requirements
Module: Imm_Encode

---
 rtl/imm_encode_if.sv | 24 ++
 rtl/imm_encode.sv | 105 ++++++++++
 tb/tb_imm_encode.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imm_encode_if.sv
// Request/result bundle for the immediate encoder: the request side and the
// result side, each with its own valid/ready handshake.
interface imm_encode_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] Imm;
  logic [1:0]  ImmSrc;
  logic [31:0] Template;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] Instr;
  logic        Range_Err;
  logic [7:0]  Err_Count;

  modport master (
    output in_valid, Imm, ImmSrc, Template, out_ready,
    input  in_ready, out_valid, Instr, Range_Err, Err_Count
  );

  modport slave (
    input  in_valid, Imm, ImmSrc, Template, out_ready,
    output in_ready, out_valid, Instr, Range_Err, Err_Count
  );
endinterface

// File: rtl/imm_encode.sv
// Two-stage immediate encoder: S1 registers the request and its range check,
// S2 holds the packed instruction and drives the result handshake.
module imm_encode (
  input  logic        clk,
  input  logic        rst,
  imm_encode_if.slave bus
);

  logic        s1_valid;
  logic [31:0] s1_imm;
  logic [1:0]  s1_src;
  logic [31:0] s1_tmpl;
  logic        s1_err;

  logic        s2_valid;
  logic [31:0] s2_instr;
  logic        s2_err;
  logic [7:0]  err_cnt;

  logic        s2_load;
  logic        in_ready;
  logic        in_fire;
  logic        out_fire;
  logic [31:0] s1_packed;

  function automatic logic [31:0] pack(logic [31:0] imm, logic [1:0] src, logic [31:0] tmpl);
    logic [31:0] r;
    r = tmpl;
    case (src)
      2'b00: r[31:20] = imm[11:0];
      2'b01: begin
        r[31:25] = imm[11:5];
        r[11:7]  = imm[4:0];
      end
      2'b10: begin
        r[31]    = imm[12];
        r[30:25] = imm[10:5];
        r[11:8]  = imm[4:1];
        r[7]     = imm[11];
      end
      default: begin
        r[31]    = imm[20];
        r[30:21] = imm[10:1];
        r[20]    = imm[11];
        r[19:12] = imm[19:12];
      end
    endcase
    return r;
  endfunction

  // Representable iff every bit from the format's sign bit upward agrees;
  // B/J targets must also be even.
  function automatic logic range_err(logic [31:0] imm, logic [1:0] src);
    logic e;
    case (src)
      2'b00, 2'b01: e = !((&imm[31:11]) || !(|imm[31:11]));
      2'b10:        e = !((&imm[31:12]) || !(|imm[31:12])) || imm[0];
      default:      e = !((&imm[31:20]) || !(|imm[31:20])) || imm[0];
    endcase
    return e;
  endfunction

  assign s2_load   = !s2_valid || bus.out_ready;
  assign in_ready  = rst && (!s1_valid || s2_load);
  assign in_fire   = bus.in_valid && in_ready;
  assign out_fire  = s2_valid && bus.out_ready;
  assign s1_packed = pack(s1_imm, s1_src, s1_tmpl);

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_valid <= 1'b0;
      s1_imm   <= '0;
      s1_src   <= '0;
      s1_tmpl  <= '0;
      s1_err   <= 1'b0;
      s2_valid <= 1'b0;
      s2_instr <= '0;
      s2_err   <= 1'b0;
      err_cnt  <= '0;
    end else begin
      if (in_ready) s1_valid <= bus.in_valid;
      if (in_fire) begin
        s1_imm  <= bus.Imm;
        s1_src  <= bus.ImmSrc;
        s1_tmpl <= bus.Template;
        s1_err  <= range_err(bus.Imm, bus.ImmSrc);
      end
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          s2_instr <= s1_packed;
          s2_err   <= s1_err;
        end
      end
      if (out_fire && s2_err && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.Instr     = s2_instr;
  assign bus.Range_Err = s2_err;
  assign bus.Err_Count = err_cnt;

endmodule

// File: tb/tb_imm_encode.sv
// Bench for imm_encode: a queue-based reference model checked every cycle,
// plus directed vectors whose results are pinned to hand-computed literals.
module tb_imm_encode;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  imm_encode_if bus();
  imm_encode dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] instr;
    logic        err;
    int          acc;
  } exp_t;

  exp_t        q[$];
  logic [31:0] dlv_instr[$];
  logic        dlv_err[$];
  int          dlv_cyc[$];
  int          mcnt = 0;
  bit          armed = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Which Imm bit lands in instruction bit p for format f, or -1 for Template.
  function automatic int src_bit(input logic [1:0] f, input int p);
    case (f)
      2'd0: return (p >= 20) ? p - 20 : -1;
      2'd1: return (p >= 25) ? p - 20 : (p >= 7 && p <= 11) ? p - 7 : -1;
      2'd2: return (p == 31) ? 12 : (p >= 25) ? p - 20 : (p >= 8 && p <= 11) ? p - 7 : (p == 7) ? 11 : -1;
      default: return (p == 31) ? 20 : (p >= 21) ? p - 20 : (p == 20) ? 11 : (p >= 12) ? p : -1;
    endcase
  endfunction

  function automatic logic [32:0] model(input logic [31:0] imm, input logic [1:0] f, input logic [31:0] t);
    int          w;
    longint      v;
    longint      lim;
    logic        e;
    logic [31:0] r;
    w   = (f == 2'd2) ? 13 : (f == 2'd3) ? 21 : 12;
    v   = longint'($signed(imm));
    lim = longint'(1) << (w - 1);
    e   = (v < -lim) || (v >= lim) || (f[1] && imm[0]);
    r   = t;
    for (int p = 0; p < 32; p++) begin
      int b;
      b = src_bit(f, p);
      if (b >= 0) r[p] = imm[b];
    end
    return {e, r};
  endfunction

  // Reference model and per-cycle compare; decisions made here take effect at the next rising edge.
  initial forever begin
    @(negedge clk);
    if (armed) begin
      logic exp_rdy;
      logic exp_ov;
      exp_rdy = rst && ((q.size() < 2) || bus.out_ready);
      exp_ov  = (q.size() > 0) && (q[0].acc < cyc);
      chk("in_ready", {31'd0, bus.in_ready}, {31'd0, exp_rdy});
      chk("out_valid", {31'd0, bus.out_valid}, {31'd0, exp_ov});
      if (exp_ov) begin
        chk("instr", bus.Instr, q[0].instr);
        chk("range_err", {31'd0, bus.Range_Err}, {31'd0, q[0].err});
      end
      chk("err_count", {24'd0, bus.Err_Count}, mcnt);
      if (!rst) begin
        q.delete();
        mcnt = 0;
      end else begin
        if (exp_ov && bus.out_ready) begin
          if (q[0].err && mcnt < 255) mcnt++;
          dlv_instr.push_back(bus.Instr);
          dlv_err.push_back(bus.Range_Err);
          dlv_cyc.push_back(cyc);
          void'(q.pop_front());
        end
        if (bus.in_valid && bus.in_ready) begin
          logic [32:0] m;
          exp_t e;
          m = model(bus.Imm, bus.ImmSrc, bus.Template);
          e.instr = m[31:0];
          e.err   = m[32];
          e.acc   = cyc + 1;
          q.push_back(e);
        end
      end
    end else if (!rst) begin
      armed = 1;
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] imm, input logic [1:0] f, input logic [31:0] t);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.Imm      = imm;
    bus.ImmSrc   = f;
    bus.Template = t;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("send_accept", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic chk_last(input string name, input logic [31:0] instr, input logic err);
    int n;
    n = dlv_instr.size();
    if (n == 0) begin
      chk({name, "_delivered"}, 32'd0, 32'd1);
    end else begin
      chk({name, "_instr"}, dlv_instr[n-1], instr);
      chk({name, "_err"}, {31'd0, dlv_err[n-1]}, {31'd0, err});
    end
  endtask

  typedef struct {
    logic [31:0] imm;
    logic [1:0]  f;
    logic [31:0] t;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[4];
    logic [32:0] m;
    int          k;
    int          n0;
    int          cnt;
    int          g;
    logic        acc;

    vecs[0] = '{32'hFFFFFFFE, 2'd3, 32'h0000006F, 32'hFFFFF06F, 1'b0};
    vecs[1] = '{32'h00001000, 2'd2, 32'h00000063, 32'h80000063, 1'b1};
    vecs[2] = '{32'hFFFFF800, 2'd1, 32'h00002023, 32'h80002023, 1'b0};
    vecs[3] = '{32'h00000005, 2'd2, 32'h00000063, 32'h00000263, 1'b1};

    m = model(32'hFFFFF800, 2'd0, 32'h00000013);
    chk("model_i", m[31:0], 32'h80000013);
    m = model(32'h00000801, 2'd3, 32'h0000006F);
    chk("model_j", {m[32], m[31:0]}, {1'b1, 32'h0010006F});
    m = model(32'hFFFFFFFC, 2'd2, 32'h00000063);
    chk("model_b", {m[32], m[31:0]}, {1'b0, 32'hFE000EE3});

    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.Imm      = '0;
    bus.ImmSrc   = '0;
    bus.Template = '0;
    bus.out_ready = 1'b1;
    idle(3);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_instr", bus.Instr, 32'd0);
    chk("rst_rerr", {31'd0, bus.Range_Err}, 32'd0);
    chk("rst_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;

    send(32'hFFFFF800, 2'd0, 32'h00000013);
    @(negedge clk);
    chk("lat_edge1_ov", {31'd0, bus.out_valid}, 32'd0);
    @(negedge clk);
    chk("lat_edge2_ov", {31'd0, bus.out_valid}, 32'd1);
    chk("scen_i_instr", bus.Instr, 32'h80000013);
    chk("scen_i_err", {31'd0, bus.Range_Err}, 32'd0);
    idle(2);

    send(32'h00000024, 2'd1, 32'h00002023);
    send(32'hFFFFFFFC, 2'd2, 32'h00000063);
    idle(4);
    n0 = dlv_instr.size();
    chk("scen_s_instr", dlv_instr[n0-2], 32'h02002223);
    chk_last("scen_b", 32'hFE000EE3, 1'b0);

    send(32'h00000801, 2'd3, 32'h0000006F);
    idle(3);
    chk_last("scen_j", 32'h0010006F, 1'b1);
    chk("scen_j_cnt", {24'd0, bus.Err_Count}, 32'd1);
    send(32'h00000800, 2'd0, 32'h00000013);
    idle(3);
    chk_last("scen_i800", 32'h80000013, 1'b1);
    chk("scen_i800_cnt", {24'd0, bus.Err_Count}, 32'd2);

    foreach (vecs[i]) begin
      send(vecs[i].imm, vecs[i].f, vecs[i].t);
      idle(3);
      chk_last("vec", vecs[i].instr, vecs[i].err);
    end

    n0 = dlv_instr.size();
    bus.out_ready = 1'b0;
    k = 0;
    for (int c = 0; c < 6; c++) begin
      bus.in_valid = (k < 3);
      bus.Imm      = k + 1;
      bus.ImmSrc   = 2'd0;
      bus.Template = 32'h00000013;
      @(negedge clk);
      acc = bus.in_valid && bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) k++;
    end
    chk("bp_accepted", k, 32'd2);
    @(negedge clk);
    chk("bp_ready", {31'd0, bus.in_ready}, 32'd0);
    chk("bp_instr_hold", bus.Instr, 32'h00100013);
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    idle(4);
    chk("bp_count", dlv_instr.size(), n0 + 3);
    if (dlv_instr.size() == n0 + 3) begin
      chk("bp_order0", dlv_instr[n0],   32'h00100013);
      chk("bp_order1", dlv_instr[n0+1], 32'h00200013);
      chk("bp_order2", dlv_instr[n0+2], 32'h00300013);
      chk("bp_rate1", dlv_cyc[n0+1] - dlv_cyc[n0], 32'd1);
      chk("bp_rate2", dlv_cyc[n0+2] - dlv_cyc[n0+1], 32'd1);
    end

    bus.in_valid = 1'b1;
    bus.Imm      = 32'h00000800;
    bus.ImmSrc   = 2'd0;
    bus.Template = 32'h00000013;
    cnt = 0;
    g   = 0;
    while (cnt < 300 && g < 1000) begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      if (acc) cnt++;
      g++;
    end
    bus.in_valid = 1'b0;
    chk("sat_sent", cnt, 32'd300);
    idle(4);
    chk("sat_count", {24'd0, bus.Err_Count}, 32'd255);

    bus.out_ready = 1'b0;
    send(32'h00000007, 2'd0, 32'h00000013);
    idle(2);
    @(negedge clk);
    chk("rst_mid_ov", {31'd0, bus.out_valid}, 32'd1);
    @(posedge clk);
    #1;
    n0 = dlv_instr.size();
    rst = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_ov_clr", {31'd0, bus.out_valid}, 32'd0);
    chk("rst_mid_cnt", {24'd0, bus.Err_Count}, 32'd0);
    chk("rst_mid_instr", bus.Instr, 32'd0);
    idle(3);
    chk("rst_mid_dropped", dlv_instr.size(), n0);

    send(32'h00000024, 2'd1, 32'h00002023);
    idle(3);
    chk_last("post_rst_s", 32'h02002223, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
